sha256_sched_stream: RTL and testbench

//  SHA-256 message-schedule transmitter for the miner datapath. Accepts one padded 512-bit block

---
 rtl/sha256_pkg.sv | 30 +++
 rtl/sha256_sched_next.sv | 15 +
 rtl/sha256_sched_stream.sv | 163 ++++++++++++++++
 tb/tb_sha256_sched_stream.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared types, constants and sigma helpers for the SHA-256 message-schedule stream.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int unsigned S0_ROT_A = 32'd7;
    localparam int unsigned S0_ROT_B = 32'd18;
    localparam int unsigned S0_SHR   = 32'd3;
    localparam int unsigned S1_ROT_A = 32'd17;
    localparam int unsigned S1_ROT_B = 32'd19;
    localparam int unsigned S1_SHR   = 32'd10;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32'd32 - n));
    endfunction

    function automatic word_t sig0(input word_t x);
        return rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
    endfunction

    function automatic word_t sig1(input word_t x);
        return rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
    endfunction

endpackage

// File: rtl/sha256_sched_next.sv
// Combinational generator of the next schedule word entering the top of the 16-word window.
module sha256_sched_next
    import sha256_pkg::*;
(
    input  word_t w_t_i,
    input  word_t w_t1_i,
    input  word_t w_t9_i,
    input  word_t w_t14_i,
    output word_t w_new_o
);

    // Modulo-2^32 sum; carries out of bit 31 are dropped by the 32-bit result.
    assign w_new_o = sig1(w_t14_i) + w_t9_i + sig0(w_t1_i) + w_t_i;

endmodule

// File: rtl/sha256_sched_stream.sv
// SHA-256 message-schedule transmitter: one padded block in, W0..W(ROUNDS-1) out.
// Optional SCHED_PREFETCH_EN adds a one-block pending register for zero-bubble streaming.
module sha256_sched_stream
    import sha256_pkg::*;
#(
    parameter int ROUNDS = 64
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    output logic         w_valid,
    input  logic         w_ready,
    output logic [31:0]  w_data,
    output logic [5:0]   w_idx,
    output logic         w_last,
    output logic         busy
);

    localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

    state_e      state_q, state_d;
    word_t       win_q [16];
    word_t       win_d [16];
    logic [5:0]  t_q, t_d;
    logic        last_q, last_d;
    word_t       w_new_s;
    logic        blk_hs_s;
    logic        w_hs_s;

`ifdef SCHED_PREFETCH_EN
    logic [511:0] pend_q, pend_d;
    logic         pend_valid_q, pend_valid_d;
`endif

    sha256_sched_next u_next (
        .w_t_i   (win_q[0]),
        .w_t1_i  (win_q[1]),
        .w_t9_i  (win_q[9]),
        .w_t14_i (win_q[14]),
        .w_new_o (w_new_s)
    );

`ifdef SCHED_PREFETCH_EN
    assign blk_ready = !pend_valid_q;
`else
    assign blk_ready = (state_q == IDLE);
`endif

    assign blk_hs_s = blk_valid && blk_ready;
    assign w_hs_s   = (state_q == STREAM) && w_ready;
    assign w_valid  = (state_q == STREAM);
    assign busy     = (state_q == STREAM);
    assign w_data   = win_q[0];
    assign w_idx    = t_q;
    assign w_last   = last_q;

    // Next-state: block load, window shift on each word handshake, end-of-block turnaround.
    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        t_d     = t_q;
        last_d  = last_q;
`ifdef SCHED_PREFETCH_EN
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
`endif
        case (state_q)
            IDLE: begin
                if (blk_hs_s) begin
                    for (int i = 0; i < 16; i++) begin
                        win_d[i] = blk_data[511 - 32*i -: 32];
                    end
                    t_d     = 6'd0;
                    last_d  = 1'b0;
                    state_d = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                if (w_hs_s && !last_q) begin
                    for (int i = 0; i < 15; i++) begin
                        win_d[i] = win_q[i + 1];
                    end
                    win_d[15] = w_new_s;
                    t_d       = t_q + 6'd1;
                    last_d    = (t_d == LAST_IDX);
                end else if (w_hs_s) begin
`ifdef SCHED_PREFETCH_EN
                    // A queued block wins; otherwise a block arriving right now bypasses straight in.
                    if (pend_valid_q) begin
                        for (int i = 0; i < 16; i++) begin
                            win_d[i] = pend_q[511 - 32*i -: 32];
                        end
                        pend_valid_d = 1'b0;
                        t_d          = 6'd0;
                        last_d       = 1'b0;
                    end else if (blk_hs_s) begin
                        for (int i = 0; i < 16; i++) begin
                            win_d[i] = blk_data[511 - 32*i -: 32];
                        end
                        t_d    = 6'd0;
                        last_d = 1'b0;
                    end else begin
                        last_d  = 1'b0;
                        state_d = IDLE;
                    end
`else
                    last_d  = 1'b0;
                    state_d = IDLE;
`endif
                end else begin
                    state_d = STREAM;
                end
`ifdef SCHED_PREFETCH_EN
                if (blk_hs_s && !(w_hs_s && last_q)) begin
                    pend_d       = blk_data;
                    pend_valid_d = 1'b1;
                end else begin
                    pend_d = pend_d;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and window registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            t_q     <= 6'd0;
            last_q  <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= 32'd0;
            end
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            last_q  <= last_d;
            win_q   <= win_d;
        end
    end

`ifdef SCHED_PREFETCH_EN
    // Pending-block register used to overlap the next block with the current stream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_q       <= 512'd0;
            pend_valid_q <= 1'b0;
        end else begin
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
        end
    end
`endif

endmodule

// File: tb/tb_sha256_sched_stream.sv
// Directed self-checking bench for sha256_sched_stream (64-round instance plus a 16-round instance).
module tb_sha256_sched_stream;

    localparam int R = 64;
`ifdef SCHED_PREFETCH_EN
    localparam int GAP = 1;
`else
    localparam int GAP = 2;
`endif
    localparam logic [511:0] ABC = {32'h61626380, 448'd0, 32'h00000018};

    logic         clk = 1'b0;
    logic         rst;
    logic         blk_valid, blk_ready, w_valid, w_ready, w_last, busy;
    logic [511:0] blk_data;
    logic [31:0]  w_data;
    logic [5:0]   w_idx;

    logic         blk_valid16, blk_ready16, w_valid16, w_ready16, w_last16, busy16;
    logic [511:0] blk_data16;
    logic [31:0]  w_data16;
    logic [5:0]   w_idx16;

    int n_checks = 0;
    int n_pass   = 0;

    logic [511:0] blk_q     [0:999];
    int           first_cyc [0:999];
    int           last_cyc  [0:999];
    logic [31:0]  exp_w     [0:63];
    logic [31:0]  got_w     [0:63];

    always #5 clk = ~clk;

    sha256_sched_stream #(.ROUNDS(64)) u_dut (
        .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx), .w_last(w_last),
        .busy(busy)
    );

    sha256_sched_stream #(.ROUNDS(16)) u_dut16 (
        .clk(clk), .rst(rst), .blk_valid(blk_valid16), .blk_ready(blk_ready16), .blk_data(blk_data16),
        .w_valid(w_valid16), .w_ready(w_ready16), .w_data(w_data16), .w_idx(w_idx16), .w_last(w_last16),
        .busy(busy16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x};
        return d[n +: 32];
    endfunction

    // Reference schedule, written as the textbook full 64-entry expansion.
    function automatic void ref_sched(input logic [511:0] b);
        logic [31:0] s0, s1;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) begin
                exp_w[t] = b[511 - 32*t -: 32];
            end else begin
                s0 = ror(exp_w[t-15], 7) ^ ror(exp_w[t-15], 18) ^ (exp_w[t-15] >> 3);
                s1 = ror(exp_w[t-2], 17) ^ ror(exp_w[t-2], 19) ^ (exp_w[t-2] >> 10);
                exp_w[t] = s1 + exp_w[t-7] + s0 + exp_w[t-16];
            end
        end
    endfunction

    // Sends blk_q[0..nblk-1] (blk_valid held unless 'late'), collects and checks every word.
    task automatic run_blocks(input int nblk, input bit rnd, input bit late, input int stop_idx,
                              input string tag);
        int sent, wblk, e, cyc, acc0, limit;
        bit acc, r, stalled, armed, done;
        logic [38:0] held;
        sent = 0; wblk = 0; e = 0; cyc = 0; acc0 = 0;
        stalled = 1'b0; armed = 1'b0; done = 1'b0; held = '0;
        limit = nblk * (rnd ? 260 : 70) + 40;
        ref_sched(blk_q[0]);
        while (!done) begin
            if (stalled) chk({tag, " hold"}, {25'd0, w_last, w_idx, w_data}, {25'd0, held});
            r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (w_valid) begin
                chk({tag, " word"}, {25'd0, w_last, w_idx, w_data},
                    {25'd0, 1'(e == R-1), 6'(e), exp_w[e]});
                if (e == 0) first_cyc[wblk] = cyc;
                if (e == R-1) begin
                    last_cyc[wblk] = cyc;
                    if (r) armed = 1'b1;
                end
                if (e == stop_idx) begin
                    w_ready   = 1'b0;
                    blk_valid = 1'b0;
                    return;
                end
            end
            blk_valid = (sent < nblk) && (!late || sent == 0 || armed);
            blk_data  = blk_valid ? blk_q[sent] : 512'd0;
            acc = blk_valid && blk_ready;
            if (acc && sent == 0) acc0 = cyc;
            if (acc) armed = 1'b0;
            w_ready = r;
            stalled = w_valid && !r;
            held    = {w_last, w_idx, w_data};
            if (w_valid && r) begin
                got_w[e] = w_data;
                e++;
                if (e == R) begin
                    e = 0;
                    wblk++;
                    if (wblk < nblk) ref_sched(blk_q[wblk]);
                    else done = 1'b1;
                end
            end
            @(posedge clk); #1;
            cyc++;
            if (acc) sent++;
            if (!done && cyc > limit) begin
                chk({tag, " timeout blocks"}, 64'(wblk), 64'(nblk));
                done = 1'b1;
            end
        end
        w_ready   = 1'b0;
        blk_valid = 1'b0;
        chk({tag, " first latency"}, 64'(first_cyc[0] - acc0), 64'(1));
        if (!rnd) begin
            for (int i = 1; i < nblk; i++) begin
                chk({tag, " gap"}, 64'(first_cyc[i] - last_cyc[i-1]), 64'(GAP));
            end
        end
        chk({tag, " end idle v/busy/rdy"}, {61'd0, w_valid, busy, blk_ready}, {61'd0, 3'b001});
    endtask

    initial begin
        int k;
        rst = 1'b1;
        blk_valid = 1'b0; blk_data = 512'd0; w_ready = 1'b0;
        blk_valid16 = 1'b0; blk_data16 = 512'd0; w_ready16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset state", {20'd0, w_valid, w_idx, w_last, busy, blk_ready, w_data},
            {20'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b1, 32'd0});
        chk("reset state r16", {27'd0, w_valid16, w_idx16, busy16, w_data16}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        blk_q[0] = ABC;
        run_blocks(1, 1'b0, 1'b0, -1, "abc");
        chk("abc W0",  {32'd0, got_w[0]},  {32'd0, 32'h61626380});
        chk("abc W15", {32'd0, got_w[15]}, {32'd0, 32'h00000018});
        chk("abc W16", {32'd0, got_w[16]}, {32'd0, 32'h61626380});
        chk("abc W17", {32'd0, got_w[17]}, {32'd0, 32'h000F0000});
        chk("abc W63", {32'd0, got_w[63]}, {32'd0, 32'h12B1EDEB});

        run_blocks(1, 1'b1, 1'b0, -1, "bp");
        chk("bp W63", {32'd0, got_w[63]}, {32'd0, 32'h12B1EDEB});

        blk_q[0] = 512'd0; blk_q[1] = ABC;
        run_blocks(2, 1'b0, 1'b0, -1, "b2b");
        chk("b2b W63", {32'd0, got_w[63]}, {32'd0, 32'h12B1EDEB});

        run_blocks(2, 1'b0, 1'b1, -1, "late");

        blk_q[0] = ABC;
        run_blocks(1, 1'b0, 1'b0, 30, "pre-rst");
        #2 rst = 1'b1;
        #1;
        chk("async rst", {25'd0, w_valid, busy, w_idx, w_data}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post-rst ready", {62'd0, blk_ready, w_valid}, {62'd0, 2'b10});
        run_blocks(1, 1'b0, 1'b0, -1, "post-rst");

        ref_sched(ABC);
        blk_valid16 = 1'b1; blk_data16 = ABC; w_ready16 = 1'b1;
        @(posedge clk); #1;
        blk_valid16 = 1'b0;
        k = 0;
        for (int c = 0; c < 24; c++) begin
            if (w_valid16) begin
                chk("r16 word", {25'd0, w_last16, w_idx16, w_data16},
                    {25'd0, 1'(k == 15), 6'(k), exp_w[k]});
                k++;
            end
            @(posedge clk); #1;
        end
        chk("r16 count", 64'(k), 64'(16));
        w_ready16 = 1'b0;

        for (int i = 0; i < 1000; i++) begin
            for (int j = 0; j < 16; j++) blk_q[i][j*32 +: 32] = $urandom();
        end
        run_blocks(1000, 1'b0, 1'b0, -1, "rand");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
